// File: rtl/mealy_seq_detector_param.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector_param
//
// Serial bit-pattern detector with a Mealy-style match output. The pattern,
// its length (1..MAX_LEN) and the overlap mode can be reprogrammed at run time.
// Every detection also goes to a registered copy and to a saturating counter.
//
// Detection keeps a short history of the previous MAX_LEN-1 accepted bits and
// a fill counter. The fill counter records how many history bits may be used
// for matching. The incoming bit is appended to the history to form a
// MAX_LEN-bit window. The low len bits of that window are compared against the
// low len bits of the pattern. The oldest bit of the pattern sits at
// [len-1] and the newest at [0].
//
// Ports
//   clk          in   1        clock, all state updates on the rising edge
//   rst          in   1        synchronous active-high reset, overrides all
//   cfg_load     in   1        strobe: capture cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  in   MAX_LEN  pattern, bit [len-1] first received
//   cfg_len      in   LW       pattern length, legal range 1..MAX_LEN
//   cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//   in_valid     in   1        in_bit carries a data bit this cycle
//   in_bit       in   1        serial data bit
//   clr_count    in   1        clear the match counter (beats a same-cycle match)
//   match        out  1        combinational, high with the completing bit
//   match_q      out  1        match delayed by one clock
//   match_count  out  CNT_W    saturating number of matches
//   cfg_err      out  1        one-cycle pulse after a rejected cfg_load
// -----------------------------------------------------------------------------
module mealy_seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1011),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  // The fill counter saturates once every history bit is meaningful.
  localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [MAX_LEN-1:0] pattern_r, pattern_d;
  logic [LW-1:0]      len_r,     len_d;
  logic               overlap_r, overlap_d;
  logic [MAX_LEN-2:0] hist_r,    hist_d;
  logic [LW-1:0]      fill_r,    fill_d;
  logic               match_r;
  logic [CNT_W-1:0]   count_r,   count_d;
  logic               cfg_err_r, cfg_err_d;

  // ---------------------------------------------------------------------------
  // Match datapath
  // ---------------------------------------------------------------------------
  logic [MAX_LEN-1:0] window;       // history with the current bit appended
  logic [MAX_LEN-1:0] len_mask;     // ones in the low len_r positions
  logic [LW:0]        fill_plus1;   // one bit wider so fill+1 never wraps
  logic               fill_ok;      // enough history for a full-length compare
  logic               pattern_hit;
  logic               accept;       // a data bit is consumed this cycle
  logic               cfg_ok;

  assign window = {hist_r, in_bit};

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
  end

  // fill >= len-1 rewritten as fill+1 >= len, which avoids any underflow
  // of len-1. len_r is always in 1..MAX_LEN, but this form does not rely on it.
  assign fill_plus1  = {1'b0, fill_r} + (LW + 1)'(1);
  assign fill_ok     = fill_plus1 >= {1'b0, len_r};

  // Pattern bits above len_r are masked off, so they never affect a match.
  assign pattern_hit = ((window ^ pattern_r) & len_mask) == '0;

  // A bit presented together with cfg_load is dropped, whatever the outcome
  // of the load.
  assign accept      = in_valid & ~cfg_load;
  assign match       = accept & ~rst & fill_ok & pattern_hit;

  assign cfg_ok      = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pattern_d = pattern_r;
    len_d     = len_r;
    overlap_d = overlap_r;
    hist_d    = hist_r;
    fill_d    = fill_r;
    cfg_err_d = 1'b0;

    if (cfg_load) begin
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
      end else begin
        // A rejected load leaves the configuration and the history intact.
        cfg_err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d = window[MAX_LEN-2:0];
      if (match && !overlap_r) begin
        // Non-overlapping mode: bits used by this match may not start
        // the next match. The history is still shifted, but it is
        // marked as empty.
        fill_d = '0;
      end else if (fill_r != FILL_MAX) begin
        fill_d = fill_r + LW'(1);
      end
    end
  end

  always_comb begin
    count_d = count_r;
    if (clr_count) begin
      count_d = '0;
    end else if (match && (count_r != '1)) begin
      count_d = count_r + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments only. All flops then
  // sample their inputs from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r <= DEF_PATTERN;
      len_r     <= LW'(DEF_LEN);
      overlap_r <= DEF_OVERLAP;
      // NOTE: the history register is cleared on reset even though fill=0
      // already masks it. This keeps the behaviour after reset independent
      // of the state before reset.
      hist_r    <= '0;
      fill_r    <= '0;
      match_r   <= 1'b0;
      count_r   <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      pattern_r <= pattern_d;
      len_r     <= len_d;
      overlap_r <= overlap_d;
      hist_r    <= hist_d;
      fill_r    <= fill_d;
      match_r   <= match;
      count_r   <= count_d;
      cfg_err_r <= cfg_err_d;
    end
  end

  assign match_q     = match_r;
  assign match_count = count_r;
  assign cfg_err     = cfg_err_r;

endmodule
